muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencing controller for the shared multi-cycle MULT/MULTU/DIV/DIVU resource beside exe_stage.
//  Accepts one request, runs a radix-2 restoring divider (32 iterations) or a fixed-latency multiplier,
//  asserts a stall to the pipeline while busy, and presents a 64-bit {HI,LO} result for one cycle.
//  Honours pipeline flush (exception) at any point.
// PARAMETERS
//  MUL_LAT  2  multiplier latency in busy cycles, legal range 1..15
// PORTS
//  cpu_clk_50M    in   1   sole clock, all state updates on rising edge
//  cpu_rst_n      in   1   synchronous reset, active-low
//  md_req_i       in   1   EXE holds a mul/div instruction; held stable with operands while stalled
//  md_op_i        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  md_src1_i      in   32  rs operand (dividend / multiplicand)
//  md_src2_i      in   32  rt operand (divisor / multiplier)
//  flush_i        in   1   pipeline flush: abort current operation
//  stallreq_md_o  out  1   pipeline stall request
//  md_valid_o     out  1   result valid (one cycle, in DONE)
//  md_hilo_o      out  64  {HI,LO}; HI=remainder/product[63:32], LO=quotient/product[31:0]
//  md_busy_o      out  1   state != IDLE
// BEHAVIOUR
//  Reset (cpu_rst_n==0 at an edge): state=IDLE, counters 0, md_valid_o=0, md_hilo_o=0, md_busy_o=0.
//  stallreq_md_o is combinational: 0 while cpu_rst_n==0; otherwise md_req_i & ~flush_i & (state!=DONE).
//  States: IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX, DONE.
//  IDLE: if md_req_i & ~flush_i, latch op and operands (magnitudes for signed DIV); then:
//   - MULT/MULTU -> MUL_BUSY, cnt=MUL_LAT-1; product computed from latched operands.
//   - DIV/DIVU with src2==0 -> DONE, result 64'h0.
//   - DIV/DIVU otherwise -> DIV_BUSY, cnt=31.
//  MUL_BUSY: cnt decrements; at cnt==0 -> DONE with signed (MULT) or unsigned (MULTU) 64-bit product.
//  DIV_BUSY: one restoring step per cycle on 33-bit partial remainder; at cnt==0 -> DIV_FIX.
//  DIV_FIX: for DIV only, negate quotient if sign(src1)^sign(src2), negate remainder if sign(src1); -> DONE.
//  DONE: md_valid_o=1, md_hilo_o=result, stallreq_md_o=0 (pipeline advances this cycle); -> IDLE unconditionally.
//  Outside DONE, md_valid_o=0 and md_hilo_o=0.
//  Latency from first request cycle in IDLE to md_valid_o:
//   DIV/DIVU = 35th cycle; MUL = MUL_LAT+2 cycle; div-by-zero = 2nd cycle.
//  Back-to-back: a request seen the cycle after DONE is a new instruction and is accepted in IDLE normally.
//  flush_i=1 in any state: next state IDLE, no result produced, md_valid_o=0 that cycle; flush has priority over DONE.
//  md_req_i dropping mid-operation (without flush) is illegal; the controller completes anyway and discards
//  the result in DONE.
//  Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0 (natural two's-complement result).
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: in IDLE, DIV/DIVU with |src1| < |src2| (post-sign magnitudes, src2!=0)
//   -> DONE directly with quotient 0 and remainder = src1 (original signed value); latency 2 cycles.
//  Undefined: such divisions take the full 35-cycle path; results are identical.
// TESTING
//  1 DIV 0xFFFFFFF9 / 0x00000002 -> stallreq 34 cycles, md_valid 35th cycle, hilo=0xFFFFFFFF_FFFFFFFD.
//  2 DIVU 0xFFFFFFFF / 0x00000010 -> hilo=0x0000000F_0FFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
//  3 DIV 5 / 0 -> md_valid on 2nd cycle, hilo=0; MULTU 0xFFFFFFFF*2 (MUL_LAT=2) -> 4th cycle, 0x00000001_FFFFFFFE.
//  4 MULT 0xFFFFFFFF*0x00000002 -> hilo=0xFFFFFFFF_FFFFFFFE; then back-to-back DIVU 100/7 -> 0x00000002_0000000E.
//  5 DIVU 100/7 with flush_i at 10th busy cycle -> IDLE next cycle, md_valid never set, stallreq 0 after
//    req drops; reset mid-DIV -> all outputs 0 next cycle.
//  6 DIVU 3/10: with MULDIV_EARLY_OUT_EN, valid on 2nd cycle; without, 35th cycle; both hilo=0x00000003_00000000.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the EXE stage and the shared mul/div controller.
interface muldiv_ctrl_if;
  logic        md_req_i;
  logic [1:0]  md_op_i;
  logic [31:0] md_src1_i;
  logic [31:0] md_src2_i;
  logic        flush_i;
  logic        stallreq_md_o;
  logic        md_valid_o;
  logic [63:0] md_hilo_o;
  logic        md_busy_o;

  modport master (
    output md_req_i, md_op_i, md_src1_i, md_src2_i, flush_i,
    input  stallreq_md_o, md_valid_o, md_hilo_o, md_busy_o
  );

  modport slave (
    input  md_req_i, md_op_i, md_src1_i, md_src2_i, flush_i,
    output stallreq_md_o, md_valid_o, md_hilo_o, md_busy_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared MULT/MULTU/DIV/DIVU unit: fixed-latency multiply, 32-step restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divisions with |src1| < |src2| finish straight from IDLE.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         cpu_clk_50M,
  input  logic         cpu_rst_n,
  muldiv_ctrl_if.slave md
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_DIV_BUSY,
    S_DIV_FIX,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        s1_q;
  logic        s2_q;
  logic [31:0] rem_q;
  logic        valid_q;
  logic [63:0] hilo_q;

  logic        sdiv_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        qbit;
  logic        sdiv_q;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;

  always_comb begin
    sdiv_in   = (md.md_op_i == 2'b10);
    a_mag     = (sdiv_in && md.md_src1_i[31]) ? -md.md_src1_i : md.md_src1_i;
    b_mag     = (sdiv_in && md.md_src2_i[31]) ? -md.md_src2_i : md.md_src2_i;
    rem_shift = {rem_q, a_q[31]};
    diff      = rem_shift - {1'b0, b_q};
    qbit      = ~diff[32];
    sdiv_q    = (op_q == 2'b10);
    quo_fix   = (sdiv_q && (s1_q ^ s2_q)) ? -a_q : a_q;
    rem_fix   = (sdiv_q && s1_q) ? -rem_q : rem_q;
    // Sign-extended operands give the signed product modulo 2^64.
    ext_a     = op_q[0] ? {32'h0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b     = op_q[0] ? {32'h0, b_q} : {{32{b_q[31]}}, b_q};
    product   = ext_a * ext_b;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      hilo_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      hilo_q  <= '0;
      if (md.flush_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (md.md_req_i) begin
              op_q  <= md.md_op_i;
              a_q   <= a_mag;
              b_q   <= b_mag;
              s1_q  <= md.md_src1_i[31];
              s2_q  <= md.md_src2_i[31];
              rem_q <= '0;
              if (!md.md_op_i[1]) begin
                state_q <= S_MUL_BUSY;
                cnt_q   <= 5'(MUL_LAT - 1);
              end else if (md.md_src2_i == '0) begin
                state_q <= S_DONE;
                valid_q <= 1'b1;
              end
`ifdef MULDIV_EARLY_OUT_EN
              else if (a_mag < b_mag) begin
                state_q <= S_DONE;
                valid_q <= 1'b1;
                hilo_q  <= {md.md_src1_i, 32'h0};
              end
`endif
              else begin
                state_q <= S_DIV_BUSY;
                cnt_q   <= 5'd31;
              end
            end
          end
          S_MUL_BUSY: begin
            if (cnt_q == '0) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              hilo_q  <= product;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          S_DIV_BUSY: begin
            // a_q shifts dividend bits out and quotient bits in.
            rem_q <= qbit ? diff[31:0] : rem_shift[31:0];
            a_q   <= {a_q[30:0], qbit};
            if (cnt_q == '0) begin
              state_q <= S_DIV_FIX;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          S_DIV_FIX: begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            hilo_q  <= {rem_fix, quo_fix};
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // A flush arriving during DONE suppresses the result in that same cycle.
  assign md.md_valid_o    = valid_q & ~md.flush_i;
  assign md.md_hilo_o     = md.flush_i ? '0 : hilo_q;
  assign md.md_busy_o     = (state_q != S_IDLE);
  assign md.stallreq_md_o = cpu_rst_n & md.md_req_i & ~md.flush_i & (state_q != S_DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: latency/result model plus directed literal vectors.
module tb_muldiv_ctrl;
  localparam int unsigned MUL_LAT = 2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 35;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   chk_en;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .md          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] v);
    longint x;
    x = (op == 2'b10) ? longint'($signed(v)) : longint'({32'h0, v});
    if (x < 0) x = -x;
    return x[31:0];
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] res;
    case (op)
      2'b00: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        res = x * y;
      end
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) res = '0;
        else begin
          x = longint'($signed(a));
          y = longint'($signed(b));
          q = x / y;
          r = x % y;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = (b == 32'h0) ? 64'h0 : {a % b, a / b};
    endcase
    return res;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[1]) return int'(MUL_LAT) + 2;
    if (b == 32'h0) return 2;
    if (EO_LAT == 2 && mag(op, a) < mag(op, b)) return 2;
    return 35;
  endfunction

  // Model: cycles-to-go countdown per accepted request.
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [63:0] m_res;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
    end else if (bus.flush_i) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (bus.md_req_i) begin
      m_res <= ref_result(bus.md_op_i, bus.md_src1_i, bus.md_src2_i);
      if (ref_lat(bus.md_op_i, bus.md_src1_i, bus.md_src2_i) == 2) m_done <= 1'b1;
      else begin
        m_busy <= 1'b1;
        m_left <= ref_lat(bus.md_op_i, bus.md_src1_i, bus.md_src2_i) - 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", {63'h0, bus.md_valid_o}, {63'h0, m_done & ~bus.flush_i});
      check("model_hilo", bus.md_hilo_o, (m_done && !bus.flush_i) ? m_res : 64'h0);
      check("model_busy", {63'h0, bus.md_busy_o}, {63'h0, m_busy | m_done});
      check("model_stall", {63'h0, bus.stallreq_md_o},
            {63'h0, rst_n & bus.md_req_i & ~bus.flush_i & ~m_done});
    end
  end

  // Starts at posedge+2; returns at posedge+2 after DONE with md_req_i dropped.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n;
    int stalls;
    bit seen;
    n = 0;
    stalls = 0;
    seen = 1'b0;
    bus.md_req_i  = 1'b1;
    bus.md_op_i   = op;
    bus.md_src1_i = a;
    bus.md_src2_i = b;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.md_valid_o) begin
        seen = 1'b1;
        n = i;
        check({name, "_hilo"}, bus.md_hilo_o, exp);
      end else if (bus.stallreq_md_o) begin
        stalls++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no md_valid_o within 60 cycles, required cycle %0d", name, exp_lat);
    end else begin
      check({name, "_lat"}, 64'(n), 64'(exp_lat));
      check({name, "_stalls"}, 64'(stalls), 64'(exp_lat - 1));
    end
    @(posedge clk);
    #2;
    bus.md_req_i = 1'b0;
  endtask

  initial begin
    int vcount;
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    bus.md_req_i  = 1'b0;
    bus.md_op_i   = 2'b00;
    bus.md_src1_i = '0;
    bus.md_src2_i = '0;
    bus.flush_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'h0, bus.md_valid_o}, 64'h0);
    check("rst_hilo", bus.md_hilo_o, 64'h0);
    check("rst_busy", {63'h0, bus.md_busy_o}, 64'h0);
    check("rst_stall", {63'h0, bus.stallreq_md_o}, 64'h0);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 35);
    run_op("divu_max_16", 2'b11, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 35);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 35);
    run_op("div_by0", 2'b10, 32'h00000005, 32'h00000000, 64'h0, 2);
    run_op("multu_max_2", 2'b01, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, 4);
    run_op("mult_m1_2", 2'b00, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 4);
    run_op("divu_100_7_b2b", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 35);
    run_op("divu_3_10", 2'b11, 32'd3, 32'd10, 64'h00000003_00000000, EO_LAT);
    run_op("div_neg7_10", 2'b10, 32'hFFFFFFF9, 32'd10, 64'hFFFFFFF9_00000000, EO_LAT);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 35);
    run_op("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 4);

    // Flush on the 10th busy cycle of a DIVU.
    bus.md_req_i  = 1'b1;
    bus.md_op_i   = 2'b11;
    bus.md_src1_i = 32'd100;
    bus.md_src2_i = 32'd7;
    repeat (10) @(posedge clk);
    #2;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall", {63'h0, bus.stallreq_md_o}, 64'h0);
    check("flush_busy_during", {63'h0, bus.md_busy_o}, 64'h1);
    @(posedge clk);
    #2;
    bus.flush_i  = 1'b0;
    bus.md_req_i = 1'b0;
    @(negedge clk);
    check("flush_busy_after", {63'h0, bus.md_busy_o}, 64'h0);
    check("flush_stall_after", {63'h0, bus.stallreq_md_o}, 64'h0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.md_valid_o) vcount++;
    end
    check("flush_no_valid", 64'(vcount), 64'h0);
    @(posedge clk);
    #2;

    // Flush together with a request in IDLE: nothing accepted.
    bus.md_req_i = 1'b1;
    bus.md_op_i  = 2'b01;
    bus.flush_i  = 1'b1;
    @(posedge clk);
    #2;
    bus.md_req_i = 1'b0;
    bus.flush_i  = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {63'h0, bus.md_busy_o}, 64'h0);
    @(posedge clk);
    #2;

    // Reset in the middle of a DIVU.
    bus.md_req_i  = 1'b1;
    bus.md_op_i   = 2'b11;
    bus.md_src1_i = 32'd100;
    bus.md_src2_i = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_stall_comb", {63'h0, bus.stallreq_md_o}, 64'h0);
    @(negedge clk);
    check("rstmid_busy", {63'h0, bus.md_busy_o}, 64'h0);
    check("rstmid_valid", {63'h0, bus.md_valid_o}, 64'h0);
    check("rstmid_hilo", bus.md_hilo_o, 64'h0);
    @(posedge clk);
    #2;
    bus.md_req_i = 1'b0;
    rst_n = 1'b1;

    run_op("divu_after_rst", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 35);
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
